spi_master_multi: RTL

//  Parametrised SPI master; successor to the fixed mode-0, 2x16-bit receive-only master.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sclk_gen.sv | 72 +++++++
 rtl/spi_master_multi.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the multi-mode SPI master.
//                - spi_state_t : controller state encoding
//                - c_MODE0..3  : SPI mode numbers as {cpol, cpha}
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5
   } spi_state_t;

   // SPI mode numbering, bit 1 = cpol, bit 0 = cpha
   localparam logic [1:0] c_MODE0 = 2'b00;
   localparam logic [1:0] c_MODE1 = 2'b01;
   localparam logic [1:0] c_MODE2 = 2'b10;
   localparam logic [1:0] c_MODE3 = 2'b11;

   // True when the mode samples MISO on the trailing SCLK edge
   function automatic logic sample_on_trail(input logic [1:0] mode);
      return (mode == c_MODE1) || (mode == c_MODE3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SCLK half-period counter and toggle.
//  Ports       : clk, rstn      clock / async active-low reset
//                load           reload the counter with div (idle phases)
//                count_en       count half-periods
//                run            toggle sclk on each expiry and count edges
//                div            half-period minus one, in clk cycles
//                idle_lvl       sclk level whenever run is low
//                tick           half-period expiry strobe
//                lead_edge      strobe: this expiry makes a leading edge
//                trail_edge     strobe: this expiry makes a trailing edge
//                edge_cnt       edges already produced in the current run
//                sclk           SPI clock
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sclk_gen #(
   parameter int CLKDIV_W = 8,
   parameter int EDGE_W   = 5
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                load,
   input  logic                count_en,
   input  logic                run,
   input  logic [CLKDIV_W-1:0] div,
   input  logic                idle_lvl,
   output logic                tick,
   output logic                lead_edge,
   output logic                trail_edge,
   output logic [EDGE_W-1:0]   edge_cnt,
   output logic                sclk
);

   logic [CLKDIV_W-1:0] r_cnt;
   logic                r_sclk;
   logic [EDGE_W-1:0]   r_edge_cnt;

   // Down-counter reloads from div at zero, so div at its maximum never wraps
   assign tick = count_en & ~load & (r_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt      <= '0;
         r_sclk     <= 1'b0;
         r_edge_cnt <= '0;
      end else begin
         if (load) begin
            r_cnt <= div;
         end else if (count_en) begin
            r_cnt <= (r_cnt == '0) ? div : (r_cnt - CLKDIV_W'(1));
         end

         if (!run) begin
            r_sclk     <= idle_lvl;
            r_edge_cnt <= '0;
         end else if (tick) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
         end
      end
   end

   // Edges alternate leading/trailing starting from the idle level
   assign lead_edge  = run & tick & ~r_edge_cnt[0];
   assign trail_edge = run & tick &  r_edge_cnt[0];
   assign edge_cnt   = r_edge_cnt;
   assign sclk       = r_sclk;

endmodule
`default_nettype wire

// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_multi
//  Description : Full-duplex MSB-first SPI master, all four CPOL/CPHA modes,
//                runtime SCLK divider, NUM_CS chip selects. Each word is sent
//                as FRAMES_PER_WORD frames with csn released between frames.
//  Ports       : clk, rstn   clock / async active-low reset
//                locked      start is ignored while low
//                start       request pulse, accepted only when idle
//                cpol, cpha, clk_div, cs_sel, tx_data   latched at start
//                busy        transfer in progress
//                done        one-cycle pulse at word completion
//                rx_data     last completed received word
//                sclk, csn, mosi, miso   SPI bus
//  Revision    : 1.0  initial release
// ============================================================================
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int  FRAME_BITS      = 16,
   parameter int  FRAMES_PER_WORD = 2,
   parameter int  NUM_CS          = 1,
   parameter int  CLKDIV_W        = 8,
   parameter int  PAUSE_CYCLES    = 2,
   localparam int WORD_BITS       = FRAME_BITS * FRAMES_PER_WORD,
   localparam int CS_W            = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 locked,
   input  logic                 start,
   input  logic                 cpol,
   input  logic                 cpha,
   input  logic [CLKDIV_W-1:0]  clk_div,
   input  logic [CS_W-1:0]      cs_sel,
   input  logic [WORD_BITS-1:0] tx_data,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_BITS-1:0] rx_data,
   output logic                 sclk,
   output logic [NUM_CS-1:0]    csn,
   output logic                 mosi,
   input  logic                 miso
);

   localparam int EDGE_W  = $clog2(2 * FRAME_BITS);
   localparam int FRM_W   = (FRAMES_PER_WORD > 1) ? $clog2(FRAMES_PER_WORD) : 1;
   localparam int PAUSE_W = $clog2(PAUSE_CYCLES + 1);

   localparam logic [EDGE_W-1:0]  c_LAST_EDGE  = EDGE_W'(2 * FRAME_BITS - 1);
   localparam logic [FRM_W-1:0]   c_LAST_FRAME = FRM_W'(FRAMES_PER_WORD - 1);
   localparam logic [PAUSE_W-1:0] c_PAUSE_END  = PAUSE_W'(PAUSE_CYCLES - 1);

   spi_state_t r_state;
   spi_state_t w_state_nxt;

   logic                 r_cpol;
   logic                 r_cpha;
   logic [CLKDIV_W-1:0]  r_div;
   logic [CS_W-1:0]      r_cs;
   logic [WORD_BITS-1:0] r_tx;
   logic [WORD_BITS-1:0] r_rx;
   logic [WORD_BITS-1:0] r_rx_data;
   logic                 r_mosi;
   logic [FRM_W-1:0]     r_frame;
   logic [PAUSE_W-1:0]   r_pause;

   logic                 w_accept;
   logic                 w_tick;
   logic                 w_lead;
   logic                 w_trail;
   logic [EDGE_W-1:0]    w_edge_cnt;
   logic                 w_last_edge;
   logic                 w_pause_end;
   logic                 w_sample;
   logic                 w_drive;
   logic                 w_trail_mode;
   logic                 w_frame_active;
   logic                 w_gen_load;
   logic                 w_gen_count;
   logic                 w_gen_run;
   logic [CLKDIV_W-1:0]  w_gen_div;
   logic                 w_idle_lvl;

   assign w_accept       = (r_state == ST_IDLE) & start & locked;
   assign w_frame_active = (r_state == ST_SETUP) | (r_state == ST_XFER) | (r_state == ST_HOLD);
   assign w_last_edge    = w_trail & (w_edge_cnt == c_LAST_EDGE);
   assign w_pause_end    = (r_state == ST_PAUSE) & (r_pause == c_PAUSE_END);

   // While idle the counter tracks the live divider so the first half-period
   // after start already uses the value latched on that same edge.
   assign w_gen_load  = (r_state == ST_IDLE) | (r_state == ST_PAUSE);
   assign w_gen_count = w_frame_active;
   assign w_gen_run   = (r_state == ST_XFER);
   assign w_gen_div   = (r_state == ST_IDLE) ? clk_div : r_div;
   assign w_idle_lvl  = w_accept ? cpol : r_cpol;

   spi_sclk_gen #(
      .CLKDIV_W (CLKDIV_W),
      .EDGE_W   (EDGE_W)
   ) u_sclk_gen (
      .clk        (clk),
      .rstn       (rstn),
      .load       (w_gen_load),
      .count_en   (w_gen_count),
      .run        (w_gen_run),
      .div        (w_gen_div),
      .idle_lvl   (w_idle_lvl),
      .tick       (w_tick),
      .lead_edge  (w_lead),
      .trail_edge (w_trail),
      .edge_cnt   (w_edge_cnt),
      .sclk       (sclk)
   );

   // cpha=0: a bit is presented at frame setup and after every trailing edge
   // except the last one of the frame (the next frame's setup presents it).
   // cpha=1: every leading edge presents the next bit.
   assign w_trail_mode = sample_on_trail({r_cpol, r_cpha});
   assign w_sample     = w_trail_mode ? w_trail : w_lead;
   assign w_drive      = w_trail_mode ? w_lead
                                      : ((w_trail & ~w_last_edge) | w_pause_end);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)    w_state_nxt = ST_SETUP;
         ST_SETUP: if (w_tick)      w_state_nxt = ST_XFER;
         ST_XFER:  if (w_last_edge) w_state_nxt = ST_HOLD;
         ST_HOLD:  if (w_tick)      w_state_nxt = (r_frame == c_LAST_FRAME) ? ST_DONE : ST_PAUSE;
         ST_PAUSE: if (w_pause_end) w_state_nxt = ST_SETUP;
         ST_DONE:                   w_state_nxt = ST_IDLE;
         default:                   w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_div     <= '0;
         r_cs      <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_mosi    <= 1'b0;
         r_frame   <= '0;
         r_pause   <= '0;
      end else begin
         if (w_accept) begin
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_div  <= clk_div;
            r_cs   <= cs_sel;
         end

         // r_tx[MSB] is always the next bit to place on mosi
         if (w_accept) begin
            r_tx   <= cpha ? tx_data : {tx_data[WORD_BITS-2:0], 1'b0};
            r_mosi <= cpha ? 1'b0 : tx_data[WORD_BITS-1];
         end else if (w_drive) begin
            r_tx   <= {r_tx[WORD_BITS-2:0], 1'b0};
            r_mosi <= r_tx[WORD_BITS-1];
         end else if (r_state == ST_DONE) begin
            r_mosi <= 1'b0;
         end

         if (w_sample) begin
            r_rx <= {r_rx[WORD_BITS-2:0], miso};
         end

         if (w_accept) begin
            r_frame <= '0;
         end else if ((r_state == ST_HOLD) && w_tick && (r_frame != c_LAST_FRAME)) begin
            r_frame <= r_frame + FRM_W'(1);
         end

         if (r_state == ST_PAUSE) begin
            r_pause <= r_pause + PAUSE_W'(1);
         end else begin
            r_pause <= '0;
         end

         if (r_state == ST_DONE) begin
            r_rx_data <= r_rx;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   // An out-of-range cs_sel matches no index, so no select is driven low.
   for (genvar i = 0; i < NUM_CS; i++) begin : g_csn
      assign csn[i] = ~(w_frame_active && (r_cs == CS_W'(i)));
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);
   assign rx_data = r_rx_data;
   assign mosi    = r_mosi;

endmodule
`default_nettype wire
